md4_round_sequencer: RTL and testbench

//  Iterative MD4 compression engine: one shared step datapath executes all 48 MD4 steps
//  (rounds 1-3), one step per clock, then adds the feed-forward into the chaining value.

---
 rtl/md4_pkg.sv | 57 +++++
 rtl/md4_step.sv | 48 ++++
 rtl/md4_round_sequencer.sv | 149 ++++++++++++++
 tb/tb_md4_round_sequencer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/md4_pkg.sv
// ---------------------------------------------------------------------------
// md4_pkg
// Shared constants and helpers for the iterative MD4 compression engine:
//   - MD4 initial chaining value (IV) in {d,c,b,a} packing
//   - per-round additive constants K0..K2
//   - per-round rotate-amount tables s0..s2 (indexed by step % 4)
//   - message-word index tables for rounds 2 and 3 (round 1 is identity)
//   - controller state enum
// ---------------------------------------------------------------------------
package md4_pkg;

    localparam logic [31:0]  IV_A = 32'h67452301;
    localparam logic [31:0]  IV_B = 32'hEFCDAB89;
    localparam logic [31:0]  IV_C = 32'h98BADCFE;
    localparam logic [31:0]  IV_D = 32'h10325476;
    localparam logic [127:0] IV   = {IV_D, IV_C, IV_B, IV_A};

    localparam logic [31:0] K0 = 32'h00000000;
    localparam logic [31:0] K1 = 32'h5A827999;
    localparam logic [31:0] K2 = 32'h6ED9EBA1;

    localparam logic [5:0] LAST_STEP = 6'd47;

    // Rotate tables, entry i at bits [5*i +: 5].
    localparam logic [19:0] S0_TAB = {5'd19, 5'd11, 5'd7, 5'd3};
    localparam logic [19:0] S1_TAB = {5'd13, 5'd9,  5'd5, 5'd3};
    localparam logic [19:0] S2_TAB = {5'd15, 5'd11, 5'd9, 5'd3};

    // Word-index tables, entry j at bits [4*j +: 4].
    // Round 2: 0,4,8,12,1,5,9,13,2,6,10,14,3,7,11,15
    localparam logic [63:0] K1_IDX = 64'hFB73_EA62_D951_C840;
    // Round 3: 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15
    localparam logic [63:0] K2_IDX = 64'hF7B3_D591_E6A2_C480;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ADD  = 2'd2
    } md4_state_e;

    function automatic logic [3:0] word_index(input logic [1:0] round, input logic [3:0] j);
        case (round)
            2'd1:    return K1_IDX[4*j +: 4];
            2'd2:    return K2_IDX[4*j +: 4];
            default: return j;
        endcase
    endfunction

    function automatic logic [4:0] step_shift(input logic [1:0] round, input logic [1:0] col);
        case (round)
            2'd0:    return S0_TAB[5*col +: 5];
            2'd1:    return S1_TAB[5*col +: 5];
            default: return S2_TAB[5*col +: 5];
        endcase
    endfunction

endpackage

// File: rtl/md4_step.sv
// ---------------------------------------------------------------------------
// md4_step
// Combinational single MD4 step: a_new = rotl(a + f_round(b,c,d) + x_word + K_round, shamt)
// Ports:
//   a, b, c, d  in  32  current working registers
//   x_word      in  32  selected message word for this step
//   round       in  2   0..2 selects boolean function and additive constant
//   shamt       in  5   rotate-left amount
//   a_new       out 32  rotated sum (becomes the new B)
// ---------------------------------------------------------------------------
module md4_step
    import md4_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] c,
    input  logic [31:0] d,
    input  logic [31:0] x_word,
    input  logic [1:0]  round,
    input  logic [4:0]  shamt,
    output logic [31:0] a_new
);
    logic [31:0] f_val;
    logic [31:0] k_val;
    logic [31:0] t_sum;

    always_comb begin
        f_val = b ^ c ^ d;
        k_val = K2;
        case (round)
            2'd0: begin
                f_val = (b & c) | (~b & d);
                k_val = K0;
            end
            2'd1: begin
                f_val = (b & c) | (b & d) | (c & d);
                k_val = K1;
            end
            default: ;
        endcase
    end

    assign t_sum = a + f_val + x_word + k_val;

    // A shift by 32 clears a 32-bit operand, so shamt=0 degenerates to t_sum.
    assign a_new = (t_sum << shamt) | (t_sum >> (6'd32 - {1'b0, shamt}));

endmodule

// File: rtl/md4_round_sequencer.sv
// ---------------------------------------------------------------------------
// md4_round_sequencer
// Iterative MD4 compression: one shared step datapath runs the 48 steps one per
// clock, then adds the feed-forward into the latched chaining value.
// Ports:
//   clk         in   1    rising-edge clock
//   rst_n       in   1    asynchronous active-low reset
//   start       in   1    compression request, honoured only in IDLE
//   abort       in   1    synchronous abort back to IDLE (no done)
//   msg_in      in   512  block, word i at [32*i +: 32]
//   chain_in    in   128  {d,c,b,a}
//   busy        out  1    high from start accept through the done cycle
//   done        out  1    one-cycle pulse, digest_out valid from then on
//   digest_out  out  128  {d,c,b,a} chaining value plus compressed state
// ---------------------------------------------------------------------------
module md4_round_sequencer
    import md4_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    input  logic [511:0] msg_in,
    input  logic [127:0] chain_in,
    output logic         busy,
    output logic         done,
    output logic [127:0] digest_out
);
    md4_state_e   state_q, state_d;
    logic [5:0]   step_q, step_d;
    logic [511:0] msg_q, msg_d;
    logic [127:0] chain_q, chain_d;
    logic [31:0]  a_q, b_q, c_q, d_q;
    logic [31:0]  a_d, b_d, c_d, d_d;
    logic         done_q, done_d;
    logic [127:0] digest_q, digest_d;

    logic [1:0]   round;
    logic [3:0]   x_idx;
    logic [31:0]  x_word;
    logic [4:0]   shamt;
    logic [31:0]  a_new;
    logic [127:0] state_vec;
    logic [127:0] sum_vec;

    assign round  = step_q[5:4];
    assign x_idx  = word_index(round, step_q[3:0]);
    assign x_word = msg_q[32*x_idx +: 32];
    assign shamt  = step_shift(round, step_q[1:0]);

    md4_step u_step (
        .a      (a_q),
        .b      (b_q),
        .c      (c_q),
        .d      (d_q),
        .x_word (x_word),
        .round  (round),
        .shamt  (shamt),
        .a_new  (a_new)
    );

    // Feed-forward: per-word modular add of chaining value and final state.
    assign state_vec = {d_q, c_q, b_q, a_q};
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_ff_add
            assign sum_vec[32*gi +: 32] = chain_q[32*gi +: 32] + state_vec[32*gi +: 32];
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        msg_d    = msg_q;
        chain_d  = chain_q;
        a_d      = a_q;
        b_d      = b_q;
        c_d      = c_q;
        d_d      = d_q;
        done_d   = 1'b0;
        digest_d = digest_q;

        case (state_q)
            IDLE: begin
                // abort outranks start when both arrive in IDLE
                if (start && !abort) begin
                    msg_d                  = msg_in;
                    chain_d                = chain_in;
                    {d_d, c_d, b_d, a_d}   = chain_in;
                    step_d                 = 6'd0;
                    state_d                = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    a_d    = d_q;
                    b_d    = a_new;
                    c_d    = b_q;
                    d_d    = c_q;
                    step_d = step_q + 6'd1;
                    if (step_q == LAST_STEP) begin
                        state_d = ADD;
                    end
                end
            end
            ADD: begin
                state_d = IDLE;
                if (!abort) begin
                    digest_d = sum_vec;
                    done_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            step_q   <= 6'd0;
            msg_q    <= '0;
            chain_q  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            d_q      <= '0;
            done_q   <= 1'b0;
            digest_q <= '0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            msg_q    <= msg_d;
            chain_q  <= chain_d;
            a_q      <= a_d;
            b_q      <= b_d;
            c_q      <= c_d;
            d_q      <= d_d;
            done_q   <= done_d;
            digest_q <= digest_d;
        end
    end

    // The done cycle is already back in IDLE, so it is folded into busy.
    assign busy       = (state_q != IDLE) || done_q;
    assign done       = done_q;
    assign digest_out = digest_q;

endmodule

// File: tb/tb_md4_round_sequencer.sv
// ---------------------------------------------------------------------------
// tb_md4_round_sequencer
// Directed bench for the iterative MD4 engine: known digests (empty, "abc",
// 80-digit two-block message), latency and handshake, held start, abort,
// asynchronous reset, and a per-step compare against an independent
// value-sequence model of MD4.
// ---------------------------------------------------------------------------
module tb_md4_round_sequencer;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [511:0] msg_in = '0;
    logic [127:0] chain_in = '0;
    logic         busy;
    logic         done;
    logic [127:0] digest_out;

    int tests_run = 0;
    int tests_failed = 0;

    localparam logic [127:0] IV_CH     = md4_pkg::IV;
    localparam logic [127:0] EXP_EMPTY = {32'hc089c0e0, 32'hd7593cb7, 32'h31e96ad1, 32'he0cfd631};
    localparam logic [127:0] EXP_ABC   = {32'h9d72a67a, 32'he80ac15f, 32'h52d821af, 32'h7a0148a4};
    localparam logic [127:0] EXP_80    = {32'h3605cc4f, 32'h167b3e9c, 32'h19f2389c, 32'hdc4d3be3};

    always #5 clk = ~clk;

    md4_round_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .msg_in     (msg_in),
        .chain_in   (chain_in),
        .busy       (busy),
        .done       (done),
        .digest_out (digest_out)
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // Reference model as a value sequence: slot n+4 holds Q[n], slots 0..3 hold
    // a, d, c, b of the incoming chaining value (Q[-4]..Q[-1]).
    logic [31:0] q_mdl [52];
    int          s_tab [12] = '{3, 7, 11, 19, 3, 5, 9, 13, 3, 9, 11, 15};

    function automatic logic [31:0] rotl32(input logic [31:0] v, input int s);
        return (v << s) | (v >> (32 - s));
    endfunction

    task automatic model_block(input logic [511:0] m, input logic [127:0] ch, output logic [127:0] dig);
        int          r;
        int          j;
        int          k;
        logic [31:0] bb, cc, dd, f, kc, t;
        q_mdl[0] = ch[31:0];
        q_mdl[1] = ch[127:96];
        q_mdl[2] = ch[95:64];
        q_mdl[3] = ch[63:32];
        for (int i = 0; i < 48; i++) begin
            r  = i / 16;
            j  = i % 16;
            bb = q_mdl[i+3];
            cc = q_mdl[i+2];
            dd = q_mdl[i+1];
            if (r == 0) begin
                f = (bb & cc) | (~bb & dd); kc = 32'h0; k = j;
            end else if (r == 1) begin
                f = (bb & cc) | (bb & dd) | (cc & dd); kc = 32'h5A827999; k = (j % 4) * 4 + j / 4;
            end else begin
                f = bb ^ cc ^ dd; kc = 32'h6ED9EBA1;
                k = ((j & 1) << 3) | ((j & 2) << 1) | ((j & 4) >> 1) | ((j & 8) >> 3);
            end
            t = q_mdl[i] + f + m[32*k +: 32] + kc;
            q_mdl[i+4] = rotl32(t, s_tab[r*4 + j%4]);
        end
        dig = {ch[127:96] + q_mdl[49], ch[95:64] + q_mdl[50],
               ch[63:32]  + q_mdl[51], ch[31:0]  + q_mdl[48]};
    endtask

    // Launch one block and wait (bounded) for done; returns at the negedge of
    // the done cycle. With trace set, compares A..D after every edge to q_mdl.
    task automatic run_block(input string tag, input logic [511:0] m, input logic [127:0] ch,
                             input bit trace, output logic [127:0] dig, output int lat);
        @(negedge clk);
        msg_in   = m;
        chain_in = ch;
        start    = 1'b1;
        @(posedge clk);
        lat = -1;
        dig = '0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (n == 0) begin
                start = 1'b0;
                check_eq({tag, " busy after accept"}, 128'(busy), 128'd1);
            end
            if (trace && n <= 48)
                check_eq($sformatf("%s state after edge %0d", tag, n),
                         {dut.a_q, dut.b_q, dut.c_q, dut.d_q},
                         {q_mdl[n], q_mdl[n+3], q_mdl[n+2], q_mdl[n+1]});
            if (done) begin
                lat = n;
                dig = digest_out;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] msg_empty, msg_abc, blk1, blk2;
        logic [127:0] dig, d1, d2, mdl1, mdl2;
        logic [7:0]   bytes [128];
        int           lat, n_done, first, second;

        msg_empty = '0;
        msg_empty[31:0] = 32'h00000080;
        msg_abc = '0;
        msg_abc[31:0]    = 32'h80636261;
        msg_abc[479:448] = 32'h00000018;

        // Reset state
        #12;
        check_eq("reset busy", 128'(busy), 128'd0);
        check_eq("reset done", 128'(done), 128'd0);
        check_eq("reset digest", digest_out, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: empty message
        run_block("empty", msg_empty, IV_CH, 1'b0, dig, lat);
        check_eq("empty latency", 128'(lat), 128'd49);
        check_eq("empty digest", dig, EXP_EMPTY);
        check_eq("empty busy in done cycle", 128'(busy), 128'd1);
        @(negedge clk);
        check_eq("empty done one cycle", 128'(done), 128'd0);
        check_eq("empty busy after done", 128'(busy), 128'd0);
        check_eq("empty digest held", digest_out, EXP_EMPTY);

        // 2: "abc"
        run_block("abc", msg_abc, IV_CH, 1'b0, dig, lat);
        check_eq("abc latency", 128'(lat), 128'd49);
        check_eq("abc digest", dig, EXP_ABC);

        // 3: start held high for 120 edges, msg_in disturbed after accept
        @(negedge clk);
        msg_in   = msg_abc;
        chain_in = IV_CH;
        start    = 1'b1;
        n_done = 0; first = -1; second = -1; d1 = '0; d2 = '0;
        for (int cyc = 0; cyc < 120; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            if (cyc == 0)  msg_in = {16{32'hdeadbeef}};
            if (cyc == 30) msg_in = msg_abc;
            if (done) begin
                n_done++;
                if (n_done == 1) begin first = cyc; d1 = digest_out; end
                else if (n_done == 2) begin second = cyc; d2 = digest_out; end
            end
        end
        start = 1'b0;
        check_eq("held start done count", 128'(n_done), 128'd2);
        check_eq("held start first done edge", 128'(first), 128'd49);
        check_eq("held start done spacing", 128'(second - first), 128'd50);
        check_eq("held start digest 1", d1, EXP_ABC);
        check_eq("held start digest 2", d2, EXP_ABC);
        // third block is in flight: abort it
        abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        abort = 1'b0;
        check_eq("abort held-start busy", 128'(busy), 128'd0);
        check_eq("abort held-start digest kept", digest_out, EXP_ABC);

        // 4: abort at step 20
        @(negedge clk);
        msg_in   = msg_empty;
        chain_in = IV_CH;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check_eq("digest not cleared on start", digest_out, EXP_ABC);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check_eq("step before abort", 128'(dut.step_q), 128'd20);
        abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        abort = 1'b0;
        check_eq("abort busy", 128'(busy), 128'd0);
        check_eq("abort done", 128'(done), 128'd0);
        n_done = 0;
        repeat (60) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check_eq("abort no done", 128'(n_done), 128'd0);
        check_eq("abort digest kept", digest_out, EXP_ABC);
        run_block("after abort", msg_empty, IV_CH, 1'b0, dig, lat);
        check_eq("after abort digest", dig, EXP_EMPTY);

        // abort and start together in IDLE: abort wins
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check_eq("abort+start idle busy", 128'(busy), 128'd0);

        // 5: asynchronous reset mid-RUN
        @(negedge clk);
        msg_in   = msg_abc;
        chain_in = IV_CH;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async reset busy", 128'(busy), 128'd0);
        check_eq("async reset done", 128'(done), 128'd0);
        check_eq("async reset digest", digest_out, 128'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        repeat (60) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check_eq("post reset no done", 128'(n_done), 128'd0);
        check_eq("post reset busy", 128'(busy), 128'd0);

        // 6: two-block message "1234567890" x 8, per-step model compare
        for (int i = 0; i < 128; i++) bytes[i] = 8'h00;
        for (int i = 0; i < 80; i++)  bytes[i] = 8'h30 + 8'((i + 1) % 10);
        bytes[80]  = 8'h80;
        bytes[120] = 8'h80;
        bytes[121] = 8'h02;
        for (int i = 0; i < 64; i++) begin
            blk1[8*i +: 8] = bytes[i];
            blk2[8*i +: 8] = bytes[64+i];
        end
        model_block(blk1, IV_CH, mdl1);
        run_block("blk1", blk1, IV_CH, 1'b1, dig, lat);
        check_eq("blk1 digest vs model", dig, mdl1);
        model_block(blk2, mdl1, mdl2);
        run_block("blk2", blk2, digest_out, 1'b1, dig, lat);
        check_eq("blk2 latency", 128'(lat), 128'd49);
        check_eq("two-block digest", dig, EXP_80);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
